mips_single_cycle_core: RTL and testbench
=========================================

// Module: mips_single_cycle_core
// PURPOSE
//  Single-cycle 32-bit MIPS core: fetch (PC + instruction memory), decode (control unit, 32x32 register
//  file, sign-extend), execute (ALU with shamt/immediate mux) and memory/write-back (data memory, MemtoReg mux).
//  Instruction memory is loaded through a write port before running. Top of the single-cycle processor.
//  Internal datapath values are exported for observation.
// PARAMETERS
//  IMEM_DEPTH  256  instruction memory words; word index PC[9:2], wraps modulo depth
//  DMEM_DEPTH  256  data memory words; word index ALUresult[9:2], wraps modulo depth
// PORTS
//  Clk           in   1   single clock, all state updates on rising edge
//  Reset         in   1   synchronous, active-high
//  WriteData     in   32  instruction word to load into instruction memory
//  WriteEnable   in   1   1 = load mode: write WriteData into imem, core frozen
//  ReadData1     out  32  register file read port 1 (rs)
//  ReadData2     out  32  register file read port 2 (rt)
//  DataMEMtoReg  out  32  write-back value (dmem read data if MemtoReg else ALUresult)
//  ALUresult     out  32  ALU output
//  ControlLines  out  12  decoded control: [11]RegDst [10]ALUSrc [9]MemtoReg [8:5]ALUCtl
//                         [4]MemWrite [3]MemRead [2]RegWrite [1]Branch [0]Jump
// BEHAVIOUR
//  - Reset (sync): PC=0, load pointer=0, all 32 registers=0. Memories keep contents; imem/dmem power up zero.
//  - Outputs are combinational from PC/instruction/state; after reset with imem[0]=0 (sll nop):
//    ReadData1=ReadData2=ALUresult=DataMEMtoReg=0, ControlLines=12'b1001_0000_0100.
//  - Load mode (WriteEnable=1, Reset=0): each edge imem[ptr]<=WriteData, ptr++ (wraps at IMEM_DEPTH);
//    PC, register file, dmem unchanged. Reset has priority over load.
//  - Run mode: one instruction per cycle; register, dmem and PC updates on same edge.
//  - Supported: R-type add,sub,and,or,nor,slt,sll,srl; addi,andi,ori,slti,lw,sw,beq,bne,j.
//    Unknown opcode/funct: all control bits 0 (no state change except PC+4).
//  - ALUCtl: 0000 AND,0001 OR,0010 ADD,0110 SUB,0111 SLT(signed),1100 NOR,1000 SLL,1001 SRL.
//    Shifts use shamt (instr[10:6]) on ReadData2. ALUSrc=1 selects immediate: sign-extended for
//    addi/slti/lw/sw, zero-extended for andi/ori. beq/bne use SUB; zero = (ALUresult==0).
//  - Overflow (signed add/sub) computed internally, no trap, write still occurs.
//  - Register write: dest = RegDst ? rd : rt; writes to $0 ignored ($0 reads 0 always).
//    Reads combinational; a write appears on read ports the cycle after.
//  - lw: MemRead=1,MemtoReg=1; dmem read combinational. sw: dmem[addr]<=ReadData2 at edge.
//  - Next PC: Jump -> {PC+4[31:28],instr[25:0],2'b00}; Branch taken (beq&zero | bne&!zero)
//    -> PC+4+(signext(imm)<<2); else PC+4. 32-bit wrap-around arithmetic.
//  - Control per class: R 1_0_0_ctl_0_0_1_0_0; lw 0_1_1_0010_0_1_1_0_0; sw 0_1_0_0010_1_0_0_0_0;
//    beq/bne 0_0_0_0110_0_0_0_1_0; j all 0 except Jump; I-ALU 0_1_0_ctl_0_0_1_0_0.
// TESTING
//  - Reset then load 0x20080005 (addi $8,$0,5) at imem[0]: run 1 cycle -> ALUresult=5,
//    ControlLines=12'b0100_0100_0100; next cycle $8 reads 5.
//  - addi $9,$0,-3; add $10,$8,$9 -> ALUresult=2; slt $11,$9,$8 -> 1; sub $0,$8,$8 -> $0 stays 0.
//  - sw $8,4($0) then lw $12,4($0) -> DataMEMtoReg=5, $12=5; ControlLines[4]/[3] pulse as decoded.
//  - beq $8,$8,+2 -> PC advances by 12; bne $8,$8,+2 -> PC+4; j 0 -> PC=0.
//  - sll $13,$8,3 -> 40; srl of 0x80000000 by 31 -> 1; add 0x7FFFFFFF+1 -> 0x80000000, no trap.
//  - Reset asserted mid-program and during load -> PC=ptr=0, registers 0, imem/dmem retained.

Source files
------------

// File: rtl/mips_single_cycle_core.sv
// Single-cycle 32-bit MIPS core with a load port into instruction memory.
// Fetch, decode, execute and write-back all complete within one clock cycle.
module mips_single_cycle_core #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] WriteData,
  input  logic        WriteEnable,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] DataMEMtoReg,
  output logic [31:0] ALUresult,
  output logic [11:0] ControlLines
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001
  } alu_op_e;

  logic [31:0]    pc_q, pc_d;
  logic [IAW-1:0] ptr_q, ptr_d;
  logic [31:0]    imem_q [IMEM_DEPTH];
  logic [31:0]    dmem_q [DMEM_DEPTH];
  logic [31:0]    regs_q [32];

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [31:0] imm_sext, imm_zext, src_b, alu_out, wb_data;
  logic [31:0] pc_plus4, branch_target, jump_target, next_pc;
  logic        reg_dst, alu_src, mem_to_reg, mem_write, mem_read, reg_write;
  logic        branch, jump, zero_ext, is_bne, taken;
  logic        imem_we, dmem_we, reg_we;
  alu_op_e     alu_ctl;

  assign instr    = imem_q[pc_q[IAW+1:2]];
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  // Unrecognised opcodes and functs fall through with every control bit low.
  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_ctl    = ALU_AND;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    zero_ext   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          6'h20:   alu_ctl = ALU_ADD;
          6'h22:   alu_ctl = ALU_SUB;
          6'h24:   alu_ctl = ALU_AND;
          6'h25:   alu_ctl = ALU_OR;
          6'h27:   alu_ctl = ALU_NOR;
          6'h2A:   alu_ctl = ALU_SLT;
          6'h00:   alu_ctl = ALU_SLL;
          6'h02:   alu_ctl = ALU_SRL;
          default: begin
            reg_dst   = 1'b0;
            reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin alu_src = 1'b1; reg_write = 1'b1; alu_ctl = ALU_ADD; end
      OP_SLTI: begin alu_src = 1'b1; reg_write = 1'b1; alu_ctl = ALU_SLT; end
      OP_ANDI: begin alu_src = 1'b1; reg_write = 1'b1; alu_ctl = ALU_AND; zero_ext = 1'b1; end
      OP_ORI:  begin alu_src = 1'b1; reg_write = 1'b1; alu_ctl = ALU_OR;  zero_ext = 1'b1; end
      OP_LW: begin
        alu_src = 1'b1; mem_to_reg = 1'b1; mem_read = 1'b1; reg_write = 1'b1; alu_ctl = ALU_ADD;
      end
      OP_SW:   begin alu_src = 1'b1; mem_write = 1'b1; alu_ctl = ALU_ADD; end
      OP_BEQ,
      OP_BNE:  begin branch = 1'b1; alu_ctl = ALU_SUB; end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

  assign ReadData1 = (rs == 5'd0) ? 32'h0 : regs_q[rs];
  assign ReadData2 = (rt == 5'd0) ? 32'h0 : regs_q[rt];
  assign src_b     = alu_src ? (zero_ext ? imm_zext : imm_sext) : ReadData2;

  // Signed overflow is not trapped: add/sub simply wrap and still write back.
  always_comb begin
    alu_out = 32'h0;
    case (alu_ctl)
      ALU_AND: alu_out = ReadData1 & src_b;
      ALU_OR:  alu_out = ReadData1 | src_b;
      ALU_ADD: alu_out = ReadData1 + src_b;
      ALU_SUB: alu_out = ReadData1 - src_b;
      ALU_SLT: alu_out = {31'd0, $signed(ReadData1) < $signed(src_b)};
      ALU_NOR: alu_out = ~(ReadData1 | src_b);
      ALU_SLL: alu_out = ReadData2 << shamt;
      ALU_SRL: alu_out = ReadData2 >> shamt;
      default: alu_out = 32'h0;
    endcase
  end

  assign ALUresult    = alu_out;
  assign wb_data      = mem_to_reg ? dmem_q[alu_out[DAW+1:2]] : alu_out;
  assign DataMEMtoReg = wb_data;
  assign dest         = reg_dst ? rd : rt;
  assign ControlLines = {reg_dst, alu_src, mem_to_reg, alu_ctl, mem_write, mem_read,
                         reg_write, branch, jump};

  assign is_bne        = (opcode == OP_BNE);
  assign taken         = branch & (is_bne ? (alu_out != 32'h0) : (alu_out == 32'h0));
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign next_pc       = jump ? jump_target : (taken ? branch_target : pc_plus4);

  // Load mode freezes the core; only the imem load pointer advances.
  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    imem_we = 1'b0;
    dmem_we = 1'b0;
    reg_we  = 1'b0;
    if (WriteEnable) begin
      imem_we = 1'b1;
      ptr_d   = ptr_q + IAW'(1);
    end else begin
      pc_d    = next_pc;
      dmem_we = mem_write;
      reg_we  = reg_write && (dest != 5'd0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= 32'h0;
      ptr_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      if (reg_we) regs_q[dest] <= wb_data;
    end
  end

  // Memories keep their contents through reset; reset only blocks writes.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (imem_we) imem_q[ptr_q] <= WriteData;
      if (dmem_we) dmem_q[alu_out[DAW+1:2]] <= ReadData2;
    end
  end
endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Self-checking bench for mips_single_cycle_core: directed program table,
// reset corner cases, then random programs against an instruction-level model.
module tb_mips_single_cycle_core;
  typedef struct {
    logic [31:0] instr;
    bit          exec;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] alu;
    logic [31:0] wb;
    logic [11:0] ctl;
  } prog_t;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        WriteEnable = 1'b0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData1, ReadData2, DataMEMtoReg, ALUresult;
  logic [11:0] ControlLines;

  int n_checks = 0;
  int n_errors = 0;

  prog_t prog[23];

  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  logic [31:0] e_rd1, e_rd2, e_alu, e_wb, n_pc;
  logic [11:0] e_ctl;
  logic [4:0]  w_dst;
  bit          w_en, s_en;

  mips_single_cycle_core #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .Clk(clk),
    .Reset(Reset),
    .WriteData(WriteData),
    .WriteEnable(WriteEnable),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .DataMEMtoReg(DataMEMtoReg),
    .ALUresult(ALUresult),
    .ControlLines(ControlLines)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic rst, input logic we, input logic [31:0] wd);
    Reset = rst;
    WriteEnable = we;
    WriteData = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] alu, input logic [31:0] wb, input logic [11:0] ctl);
    check_output({tag, " ReadData1"}, ReadData1, rd1);
    check_output({tag, " ReadData2"}, ReadData2, rd2);
    check_output({tag, " ALUresult"}, ALUresult, alu);
    check_output({tag, " DataMEMtoReg"}, DataMEMtoReg, wb);
    check_output({tag, " ControlLines"}, {20'h0, ControlLines}, {20'h0, ctl});
  endtask

  function automatic logic [11:0] mk_ctl(bit rdst, bit asrc, bit m2r, logic [3:0] op,
                                         bit mw, bit mr, bit rw, bit br, bit jp);
    return {rdst, asrc, m2r, op, mw, mr, rw, br, jp};
  endfunction

  // Architectural effect of the instruction at m_pc, computed straight from the ISA rules.
  task automatic model_eval();
    logic [31:0] ins, a, b, sext, zext, pc4;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    bit          rvalid, is_load;
    logic [3:0]  rc;
    ins  = m_imem[m_pc[9:2]];
    op   = ins[31:26];
    fn   = ins[5:0];
    sh   = ins[10:6];
    a    = m_regs[ins[25:21]];
    b    = m_regs[ins[20:16]];
    sext = {{16{ins[15]}}, ins[15:0]};
    zext = {16'h0, ins[15:0]};
    pc4  = m_pc + 32'd4;
    e_rd1 = a;
    e_rd2 = b;
    e_alu = a & b;
    e_ctl = 12'h0;
    w_en = 0; s_en = 0; is_load = 0;
    w_dst = ins[20:16];
    n_pc = pc4;
    case (op)
      6'h00: begin
        rvalid = 1; rc = 4'b0000;
        case (fn)
          6'h20: begin e_alu = a + b; rc = 4'b0010; end
          6'h22: begin e_alu = a - b; rc = 4'b0110; end
          6'h24: begin e_alu = a & b; rc = 4'b0000; end
          6'h25: begin e_alu = a | b; rc = 4'b0001; end
          6'h27: begin e_alu = ~(a | b); rc = 4'b1100; end
          6'h2A: begin e_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; rc = 4'b0111; end
          6'h00: begin e_alu = b << sh; rc = 4'b1000; end
          6'h02: begin e_alu = b >> sh; rc = 4'b1001; end
          default: rvalid = 0;
        endcase
        if (rvalid) begin
          e_ctl = mk_ctl(1, 0, 0, rc, 0, 0, 1, 0, 0);
          w_en = 1;
          w_dst = ins[15:11];
        end
      end
      6'h08: begin e_alu = a + sext; e_ctl = mk_ctl(0, 1, 0, 4'b0010, 0, 0, 1, 0, 0); w_en = 1; end
      6'h0C: begin e_alu = a & zext; e_ctl = mk_ctl(0, 1, 0, 4'b0000, 0, 0, 1, 0, 0); w_en = 1; end
      6'h0D: begin e_alu = a | zext; e_ctl = mk_ctl(0, 1, 0, 4'b0001, 0, 0, 1, 0, 0); w_en = 1; end
      6'h0A: begin
        e_alu = ($signed(a) < $signed(sext)) ? 32'd1 : 32'd0;
        e_ctl = mk_ctl(0, 1, 0, 4'b0111, 0, 0, 1, 0, 0);
        w_en = 1;
      end
      6'h23: begin
        e_alu = a + sext; is_load = 1; w_en = 1;
        e_ctl = mk_ctl(0, 1, 1, 4'b0010, 0, 1, 1, 0, 0);
      end
      6'h2B: begin e_alu = a + sext; s_en = 1; e_ctl = mk_ctl(0, 1, 0, 4'b0010, 1, 0, 0, 0, 0); end
      6'h04, 6'h05: begin
        e_alu = a - b;
        e_ctl = mk_ctl(0, 0, 0, 4'b0110, 0, 0, 0, 1, 0);
        if ((op == 6'h04) == (a == b)) n_pc = pc4 + (sext << 2);
      end
      6'h02: begin
        e_ctl = mk_ctl(0, 0, 0, 4'b0000, 0, 0, 0, 0, 1);
        n_pc = {pc4[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    e_wb = is_load ? m_dmem[e_alu[9:2]] : e_alu;
  endtask

  task automatic model_commit();
    if (w_en && w_dst != 5'd0) m_regs[w_dst] = e_wb;
    if (s_en) m_dmem[e_alu[9:2]] = e_rd2;
    m_pc = n_pc;
  endtask

  // Registers limited to $0..$7 so branch operands often match and $0 writes are frequent.
  function automatic logic [31:0] gen_instr();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [5:0]  fn, op;
    int k;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    sh  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    k   = $urandom_range(0, 19);
    if (k <= 5) begin
      case ($urandom_range(0, 7))
        0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
        4: fn = 6'h27; 5: fn = 6'h2A; 6: fn = 6'h00; default: fn = 6'h02;
      endcase
      return {6'h00, rs, rt, rd, sh, fn};
    end else if (k <= 9) begin
      case ($urandom_range(0, 3))
        0: op = 6'h08; 1: op = 6'h0C; 2: op = 6'h0D; default: op = 6'h0A;
      endcase
      return {op, rs, rt, imm};
    end else if (k <= 11) begin
      return {6'h23, 5'd0, rt, 16'($urandom_range(0, 15) * 4)};
    end else if (k <= 13) begin
      return {6'h2B, 5'd0, rt, 16'($urandom_range(0, 15) * 4)};
    end else if (k <= 16) begin
      op = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
      return {op, rs, rt, 16'($urandom_range(0, 4))};
    end else if (k == 17) begin
      return {6'h02, 26'($urandom)};
    end else begin
      case ($urandom_range(0, 3))
        0: return {6'h0F, rs, rt, imm};
        1: return {6'h3F, rs, rt, imm};
        2: return {6'h00, rs, rt, rd, sh, 6'h21};
        default: return {6'h00, rs, rt, rd, sh, 6'h08};
      endcase
    end
  endfunction

  initial begin
    prog[0]  = '{32'h20080005, 1, 32'h0,        32'h0,        32'h5,        32'h5,        12'h444};
    prog[1]  = '{32'h2009FFFD, 1, 32'h0,        32'h0,        32'hFFFFFFFD, 32'hFFFFFFFD, 12'h444};
    prog[2]  = '{32'h01095020, 1, 32'h5,        32'hFFFFFFFD, 32'h2,        32'h2,        12'h844};
    prog[3]  = '{32'h0128582A, 1, 32'hFFFFFFFD, 32'h5,        32'h1,        32'h1,        12'h8E4};
    prog[4]  = '{32'h01080022, 1, 32'h5,        32'h5,        32'h0,        32'h0,        12'h8C4};
    prog[5]  = '{32'h00087025, 1, 32'h0,        32'h5,        32'h5,        32'h5,        12'h824};
    prog[6]  = '{32'hAC080004, 1, 32'h0,        32'h5,        32'h4,        32'h4,        12'h450};
    prog[7]  = '{32'h8C0C0004, 1, 32'h0,        32'h0,        32'h4,        32'h5,        12'h64C};
    prog[8]  = '{32'h000868C0, 1, 32'h0,        32'h5,        32'h28,       32'h28,       12'h904};
    prog[9]  = '{32'h01807825, 1, 32'h5,        32'h0,        32'h5,        32'h5,        12'h824};
    prog[10] = '{32'h11080002, 1, 32'h5,        32'h5,        32'h0,        32'h0,        12'h0C2};
    prog[11] = '{32'h20100011, 0, 32'h0,        32'h0,        32'h0,        32'h0,        12'h000};
    prog[12] = '{32'h20100022, 0, 32'h0,        32'h0,        32'h0,        32'h0,        12'h000};
    prog[13] = '{32'h15080002, 1, 32'h5,        32'h5,        32'h0,        32'h0,        12'h0C2};
    prog[14] = '{32'h20110007, 1, 32'h0,        32'h0,        32'h7,        32'h7,        12'h444};
    prog[15] = '{32'h20120001, 1, 32'h0,        32'h0,        32'h1,        32'h1,        12'h444};
    prog[16] = '{32'h001297C0, 1, 32'h0,        32'h1,        32'h80000000, 32'h80000000, 12'h904};
    prog[17] = '{32'h00129FC2, 1, 32'h0,        32'h80000000, 32'h1,        32'h1,        12'h924};
    prog[18] = '{32'h0240A027, 1, 32'h80000000, 32'h0,        32'h7FFFFFFF, 32'h7FFFFFFF, 12'h984};
    prog[19] = '{32'h0293A820, 1, 32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h80000000, 12'h844};
    prog[20] = '{32'h02A0B025, 1, 32'h80000000, 32'h0,        32'h80000000, 32'h80000000, 12'h824};
    prog[21] = '{32'hFC000000, 1, 32'h0,        32'h0,        32'h0,        32'h0,        12'h000};
    prog[22] = '{32'h08000000, 1, 32'h0,        32'h0,        32'h0,        32'h0,        12'h001};

    // Reset state with a nop (all-zero word) at imem[0].
    apply_stimulus(1, 0, 32'h0);
    apply_stimulus(1, 0, 32'h0);
    apply_stimulus(0, 1, 32'h0);
    apply_stimulus(1, 0, 32'h0);
    Reset = 0;
    #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 12'h904);

    // Directed program: arithmetic, $0 protection, sw/lw, branches, shifts, wrap, unknown op, jump.
    for (int i = 0; i < 23; i++) apply_stimulus(0, 1, prog[i].instr);
    WriteEnable = 0;
    #1;
    for (int i = 0; i < 23; i++) begin
      if (prog[i].exec) begin
        check_all($sformatf("prog[%0d]", i), prog[i].rd1, prog[i].rd2, prog[i].alu,
                  prog[i].wb, prog[i].ctl);
        apply_stimulus(0, 0, 32'h0);
      end
    end
    check_all("after j", 32'h0, 32'h5, 32'h5, 32'h5, 12'h444);
    apply_stimulus(0, 0, 32'h0);

    // Reset mid-program: back to imem[0] with registers cleared.
    apply_stimulus(1, 0, 32'h0);
    Reset = 0;
    #1;
    check_all("mid reset", 32'h0, 32'h0, 32'h5, 32'h5, 12'h444);
    apply_stimulus(0, 0, 32'h0);

    // Reset during load: pointer returns to 0, imem[2] and dmem[1] keep old contents.
    apply_stimulus(0, 1, 32'hFC000000);
    apply_stimulus(0, 1, 32'hFC000000);
    apply_stimulus(1, 1, 32'hFC000000);
    apply_stimulus(0, 1, 32'h20020009);
    apply_stimulus(0, 1, 32'h8C010004);
    WriteEnable = 0;
    #1;
    check_all("load rst w0", 32'h0, 32'h0, 32'h9, 32'h9, 12'h444);
    apply_stimulus(0, 0, 32'h0);
    check_all("load rst w1", 32'h0, 32'h0, 32'h4, 32'h5, 12'h64C);
    apply_stimulus(0, 0, 32'h0);
    check_all("load rst w2", 32'h0, 32'h0, 32'h0, 32'h0, 12'h844);

    // Random program over the full imem; a prologue zeroes the dmem words lw/sw may touch.
    apply_stimulus(1, 0, 32'h0);
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    for (int i = 0; i < 256; i++) m_dmem[i] = 32'h0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = (i < 16) ? (32'hAC000000 | 32'(i * 4)) : gen_instr();
      m_imem[i] = w;
      apply_stimulus(0, 1, w);
    end
    WriteEnable = 0;
    #1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      model_eval();
      check_all($sformatf("rand c%0d pc=%h", cyc, m_pc), e_rd1, e_rd2, e_alu, e_wb, e_ctl);
      model_commit();
      apply_stimulus(0, 0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
